// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider controller.
//   - DIV_WIDTH_DEFAULT : default operand width in bits
//   - divState_e        : controller FSM state encoding
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // The controller walks IDLE -> (DIV_ZERO | DIV_ON) -> DIV_END -> IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } divState_e;

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational restoring shift-subtract step.
//   i_rem     : current partial remainder (always < i_divisor)
//   i_bit     : next dividend bit shifted into the partial remainder
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_qBit    : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qBit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    // Because i_rem < i_divisor, a non-negative difference always fits in
    // WIDTH bits, so bit WIDTH of the difference is a clean borrow flag.
    always_comb begin
        w_shifted = {i_rem, i_bit};
        w_diff    = w_shifted - {1'b0, i_divisor};
        o_qBit    = ~w_diff[WIDTH];
        o_rem     = o_qBit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
// Multi-cycle DIV/DIVU unit for the Execute stage. One restoring step per
// cycle; the result is sign-corrected as it is written into result_o.
//   clk       : clock, all state updates on the rising edge
//   resetn    : synchronous active-low reset
//   start_i   : DIV/DIVU in Execute
//   signed_i  : 1 = DIV (two's complement), 0 = DIVU
//   opdata1_i : dividend
//   opdata2_i : divisor
//   annul_i   : pipeline flush, cancels any operation in flight
//   result_o  : {remainder (HI), quotient (LO)}, held until the next result
//   ready_o   : one-cycle pulse while result_o carries a fresh result
//   stall_o   : stall request for the F, D and E stages
// ---------------------------------------------------------------------------
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    divState_e          r_state;
    divState_e          w_nextState;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_negDividend;
    logic               r_negDivisor;
    logic [2*WIDTH-1:0] r_result;

    logic               w_accept;
    logic               w_zeroDivisor;
    logic               w_lastStep;
    logic [WIDTH-1:0]   w_absDividend;
    logic [WIDTH-1:0]   w_absDivisor;
    logic [WIDTH-1:0]   w_stepRem;
    logic               w_stepQBit;
    logic [WIDTH-1:0]   w_quotRaw;
    logic [WIDTH-1:0]   w_finalQuot;
    logic [WIDTH-1:0]   w_finalRem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quot[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_qBit    (w_stepQBit)
    );

    // Operand conditioning and final sign correction. r_quot doubles as the
    // dividend shift register: dividend bits leave at the top while quotient
    // bits enter at the bottom. Negation is modulo 2^WIDTH, which is what
    // makes MIN / -1 come out as MIN without any special case.
    always_comb begin
        w_accept      = start_i & ~annul_i;
        w_zeroDivisor = (opdata2_i == '0);
        w_lastStep    = (r_count == LAST_STEP);
        w_absDividend = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        w_absDivisor  = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        w_quotRaw     = {r_quot[WIDTH-2:0], w_stepQBit};
        w_finalQuot   = (r_negDividend ^ r_negDivisor) ? -w_quotRaw : w_quotRaw;
        w_finalRem    = r_negDividend ? -w_stepRem : w_stepRem;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. A flush in any busy state drops
    // straight back to IDLE; DIV_END never stalls so the pipeline moves on
    // in the same cycle the result is presented.
    always_comb begin
        w_nextState = r_state;
        stall_o     = 1'b0;
        ready_o     = 1'b0;
        case (r_state)
            IDLE: begin
                stall_o = w_accept;
                if (w_accept) begin
                    w_nextState = w_zeroDivisor ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                stall_o     = ~annul_i;
                w_nextState = annul_i ? IDLE : DIV_END;
            end
            DIV_ON: begin
                stall_o = ~annul_i;
                if (annul_i) begin
                    w_nextState = IDLE;
                end else if (w_lastStep) begin
                    w_nextState = DIV_END;
                end
            end
            DIV_END: begin
                ready_o     = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath. Operands are captured only when IDLE accepts a start; the
    // sign flags are only ever set for signed operations. For a zero divisor
    // the raw dividend is kept so it can be returned unchanged as remainder.
    // result_o is written only on the way into DIV_END, so a flush leaves it
    // untouched.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count       <= '0;
            r_rem         <= '0;
            r_quot        <= '0;
            r_divisor     <= '0;
            r_negDividend <= 1'b0;
            r_negDivisor  <= 1'b0;
            r_result      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_count       <= '0;
                        r_rem         <= '0;
                        r_divisor     <= w_absDivisor;
                        r_negDividend <= signed_i & opdata1_i[WIDTH-1];
                        r_negDivisor  <= signed_i & opdata2_i[WIDTH-1];
                        r_quot        <= w_zeroDivisor ? opdata1_i : w_absDividend;
                    end
                end
                DIV_ZERO: begin
                    if (!annul_i) begin
                        r_result <= {r_quot, {WIDTH{1'b1}}};
                    end
                end
                DIV_ON: begin
                    if (!annul_i) begin
                        r_rem   <= w_stepRem;
                        r_quot  <= w_quotRaw;
                        r_count <= r_count + CNT_ONE;
                        if (w_lastStep) begin
                            r_result <= {w_finalRem, w_finalQuot};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o = r_result;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start_i, input, 1 bit: a DIV/DIVU instruction is in the Execute stage.
REQ-005 SHALL have port signed_i, input, 1 bit: 1 selects DIV (two's complement), 0 selects DIVU.
REQ-006 SHALL have port opdata1_i, input, WIDTH bits: dividend (rs).
REQ-007 SHALL have port opdata2_i, input, WIDTH bits: divisor (rt).
REQ-008 SHALL have port annul_i, input, 1 bit: cancels the operation in flight (pipeline flush).
REQ-009 SHALL have port result_o, output, 2*WIDTH bits: {remainder -> HI, quotient -> LO}.
REQ-010 SHALL have port ready_o, output, 1 bit: one-cycle pulse, result_o valid.
REQ-011 SHALL have port stall_o, output, 1 bit: request to the hazard unit to stall the F, D and E stages.

Function
REQ-012 SHALL implement FSM states IDLE, DIV_ZERO, DIV_ON and DIV_END.
REQ-013 IDLE, on start_i=1 and annul_i=0:
- if opdata2_i == 0, SHALL go to DIV_ZERO;
- otherwise SHALL latch |dividend|, |divisor| (magnitudes only when signed_i=1) plus the sign bits, clear the step counter, and go to DIV_ON.
REQ-014 DIV_ON SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to DIV_END.
REQ-015 DIV_ZERO SHALL last one cycle and go to DIV_END, producing quotient = all ones and remainder = dividend unchanged.
REQ-016 On entry to DIV_END, for signed operation, result SHALL be sign-corrected:
- quotient negated when the operand signs differ;
- remainder negated when the dividend is negative.
REQ-017 Arithmetic SHALL be modulo 2^WIDTH; signed MIN / -1 SHALL give quotient 0x80000000 and remainder 0 with no special case.
REQ-018 DIV_END SHALL assert ready_o for exactly one cycle and SHALL return to IDLE next cycle.
REQ-019 Latency: for a start seen in IDLE at cycle t, ready_o SHALL assert at t+WIDTH+1 (nonzero divisor) or at t+2 (zero divisor).
REQ-020 stall_o SHALL be combinational and equal to ((IDLE & start_i) | DIV_ZERO | DIV_ON) & ~annul_i; it SHALL be 0 in DIV_END so the pipeline advances in that cycle.
REQ-021 Back-to-back divides: start_i=1 in the IDLE cycle after DIV_END SHALL begin a new operation.
REQ-022 annul_i=1 in any non-IDLE state SHALL force IDLE next cycle, with no ready_o pulse and result_o unchanged.
REQ-023 Operands SHALL be sampled only in IDLE; changes on opdata*_i or signed_i during DIV_ON SHALL be ignored.
REQ-024 result_o SHALL hold its last value until the next DIV_END.

Reset
REQ-025 resetn=0 at a clock edge SHALL force IDLE, counter 0, result_o 0, ready_o 0, including mid-operation; stall_o SHALL then follow REQ-020.
REQ-026 No operation in flight at reset SHALL later produce ready_o.

Structure
REQ-027 The FSM state enum and the default WIDTH constant SHALL live in the shared package div_pkg.
REQ-028 The single-step restoring subtract (partial remainder, divisor -> next partial remainder, quotient bit) SHALL be the combinational sub-module div_step.
REQ-029 The counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-030 Unsigned 100/7, start at t: stall_o=1 for t..t+32, ready_o at t+33, result_o = {0x00000002, 0x0000000E}.
REQ-031 Signed -7/2: result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2: {0x00000001, 0xFFFFFFFD}.
REQ-032 5/0 (either sign mode): ready_o at t+2, result_o = {0x00000005, 0xFFFFFFFF}.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF: result_o = {0x00000000, 0x80000000}.
REQ-034 annul_i=1 at t+10 of a divide: stall_o=0 that cycle, IDLE at t+11, no ready_o, result_o unchanged; resetn=0 at t+5 gives the same outcome.
REQ-035 Two back-to-back divides (start_i held through): two ready_o pulses 34 cycles apart, each with the correct result.
